// File: rtl/symbol_bits_packer.sv
// Packs N-bit hard-decision groups into OUT_WIDTH-bit words; flush closes a zero-padded partial word.
// Latency: a word is on out_valid one cycle after its last group (or the flush) is taken, if the output register is free.
// Backpressure: one output holding register; one full word parks in acc, then in_ready drops until it moves out.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   in_bits/in_valid/in_ready decision bits (bit i = symbol i) with valid/ready handshake
//   flush                     single-cycle request to close the current word
//   out_data/out_nbits/out_last/out_valid/out_ready
//                             packed word, count of meaningful bits, closed-by-flush marker, handshake
module symbol_bits_packer #(
    parameter int N         = 1,
    parameter int OUT_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N-1:0]                   in_bits,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           flush,
    output logic [OUT_WIDTH-1:0]           out_data,
    output logic [$clog2(OUT_WIDTH+1)-1:0] out_nbits,
    output logic                           out_last,
    output logic                           out_valid,
    input  logic                           out_ready
);

    localparam int GROUPS = OUT_WIDTH / N;
    localparam int CW     = $clog2(GROUPS + 1);
    localparam int NBW    = $clog2(OUT_WIDTH + 1);

    localparam logic [CW-1:0]  GROUPS_C = CW'(GROUPS);
    localparam logic [NBW-1:0] FULL_C   = NBW'(OUT_WIDTH);
    localparam logic [NBW-1:0] N_C      = NBW'(N);

    generate
        if (N < 1 || (OUT_WIDTH % N) != 0) begin : g_bad_params
            $error("symbol_bits_packer: OUT_WIDTH must be a positive multiple of N");
        end
    endgenerate

    logic [OUT_WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 flush_pend_q, flush_pend_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic [NBW-1:0]       out_nbits_q, out_nbits_d;
    logic                 out_last_q, out_last_d;
    logic                 out_valid_q, out_valid_d;

    logic                 accept;
    logic                 out_free;
    logic                 flush_req;
    logic [OUT_WIDTH-1:0] acc_wr;
    logic [CW-1:0]        cnt_acc;
    logic                 emit;
    logic [OUT_WIDTH-1:0] emit_data;
    logic [NBW-1:0]       emit_nbits;
    logic                 emit_last;

    // cnt==GROUPS means a complete word is parked in acc waiting for the output register.
    assign in_ready  = !rst && (cnt_q != GROUPS_C) && !flush_pend_q;
    assign accept    = in_valid && in_ready;
    assign out_free  = !out_valid_q || out_ready;
    // A second flush while one is already pending is ignored.
    assign flush_req = flush && !flush_pend_q;

    always_comb begin
        // acc with this cycle's group (if any) merged in; cnt_acc is the count including it.
        acc_wr = acc_q;
        for (int g = 0; g < GROUPS; g++) begin
            if (accept && cnt_q == CW'(g)) begin
                acc_wr[g*N +: N] = in_bits;
            end
        end
        cnt_acc = accept ? cnt_q + CW'(1) : cnt_q;

        acc_d        = acc_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        out_data_d   = out_data_q;
        out_nbits_d  = out_nbits_q;
        out_last_d   = out_last_q;
        out_valid_d  = out_valid_q;
        emit         = 1'b0;
        emit_data    = acc_wr;
        emit_nbits   = FULL_C;
        emit_last    = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (cnt_q == GROUPS_C) begin
            // Parked full word: move it as soon as the output register frees up.
            if (out_free) begin
                emit      = 1'b1;
                emit_data = acc_q;
                emit_last = flush_pend_q || flush_req;
            end else begin
                flush_pend_d = flush_pend_q || flush_req;
            end
        end else if (cnt_acc == GROUPS_C) begin
            // This cycle's group completes the word; bypass acc when possible so there is no bubble.
            if (out_free) begin
                emit      = 1'b1;
                emit_last = flush_req;
            end else begin
                acc_d        = acc_wr;
                cnt_d        = GROUPS_C;
                flush_pend_d = flush_req;
            end
        end else if ((flush_pend_q || flush_req) && cnt_acc != '0) begin
            // Partial word closed by flush; a group taken this same cycle belongs to it.
            if (out_free) begin
                emit       = 1'b1;
                emit_nbits = NBW'(cnt_acc) * N_C;
                emit_last  = 1'b1;
            end else begin
                acc_d        = acc_wr;
                cnt_d        = cnt_acc;
                flush_pend_d = 1'b1;
            end
        end else begin
            acc_d = acc_wr;
            cnt_d = cnt_acc;
        end

        // acc is cleared whenever a word leaves, so bits above the fill level are always zero.
        if (emit) begin
            out_data_d   = emit_data;
            out_nbits_d  = emit_nbits;
            out_last_d   = emit_last;
            out_valid_d  = 1'b1;
            acc_d        = '0;
            cnt_d        = '0;
            flush_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            out_data_q   <= '0;
            out_nbits_q  <= '0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            out_data_q   <= out_data_d;
            out_nbits_q  <= out_nbits_d;
            out_last_q   <= out_last_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_nbits = out_nbits_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_symbol_bits_packer.sv
module tb_symbol_bits_packer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: N=1, OUT_WIDTH=8
    logic [0:0] a_in_bits;
    logic       a_in_valid, a_in_ready, a_flush;
    logic [7:0] a_out_data;
    logic [3:0] a_out_nbits;
    logic       a_out_last, a_out_valid, a_out_ready;

    // Instance B: N=4, OUT_WIDTH=8
    logic [3:0] b_in_bits;
    logic       b_in_valid, b_in_ready, b_flush;
    logic [7:0] b_out_data;
    logic [3:0] b_out_nbits;
    logic       b_out_last, b_out_valid, b_out_ready;

    symbol_bits_packer #(.N(1), .OUT_WIDTH(8)) dut_a (
        .clk(clk), .rst(rst),
        .in_bits(a_in_bits), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .flush(a_flush),
        .out_data(a_out_data), .out_nbits(a_out_nbits), .out_last(a_out_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready)
    );

    symbol_bits_packer #(.N(4), .OUT_WIDTH(8)) dut_b (
        .clk(clk), .rst(rst),
        .in_bits(b_in_bits), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .flush(b_flush),
        .out_data(b_out_data), .out_nbits(b_out_nbits), .out_last(b_out_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard for instance A: a reference packer pushes expected words as groups are accepted.
    typedef struct {
        logic [7:0] d;
        logic [3:0] nb;
        logic       l;
    } word_t;
    word_t      sb[$];
    logic [7:0] m_acc = '0;
    int         m_cnt = 0;
    int         pop_cyc_prev = 0;
    int         pop_cyc_last = 0;

    always @(negedge clk) begin
        word_t w;
        if (rst) begin
            m_acc = '0;
            m_cnt = 0;
            sb.delete();
        end else begin
            if (a_in_valid && a_in_ready) begin
                m_acc[m_cnt] = a_in_bits[0];
                m_cnt++;
            end
            if (m_cnt == 8) begin
                w.d = m_acc; w.nb = 4'd8; w.l = a_flush;
                sb.push_back(w);
                m_acc = '0; m_cnt = 0;
            end else if (a_flush && m_cnt > 0) begin
                w.d = m_acc; w.nb = 4'(m_cnt); w.l = 1'b1;
                sb.push_back(w);
                m_acc = '0; m_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        word_t e;
        if (!rst && a_out_valid && a_out_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_word", 32'(a_out_data), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("sb_data",  32'(a_out_data),  32'(e.d));
                check("sb_nbits", 32'(a_out_nbits), 32'(e.nb));
                check("sb_last",  32'(a_out_last),  32'(e.l));
                pop_cyc_prev = pop_cyc_last;
                pop_cyc_last = cyc;
            end
        end
    end

    // Cycle-level vectors for instance A: inputs for one cycle, outputs expected in that cycle.
    typedef struct {
        logic       rst, vld, din, fl, ordy;
        logic       ov;
        logic [7:0] dat;
        logic [3:0] nb;
        logic       last, irdy, full;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input int r, input int v, input int d, input int f, input int o,
                                input int ev, input int ed, input int en, input int el,
                                input int er, input int ef);
        vec_t t;
        t.rst = (r != 0); t.vld = (v != 0); t.din = (d != 0); t.fl = (f != 0); t.ordy = (o != 0);
        t.ov = (ev != 0); t.dat = 8'(ed); t.nb = 4'(en); t.last = (el != 0);
        t.irdy = (er != 0); t.full = (ef != 0);
        vecs.push_back(t);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1);
    end

    initial begin
        logic [7:0]  p8d;
        logic [7:0]  p3c;
        logic [15:0] pat;
        logic        got;
        p8d = 8'h8D;
        p3c = 8'h3C;
        pat = 16'h3C8D;

        rst = 1'b1;
        a_in_bits = '0; a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b1;
        b_in_bits = '0; b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b1;

        // reset state, then one full word 0x8D
        add(1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) add(0, 1, int'(p8d[i]), 0, 1,  0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 1,  1, 'h8D, 8, 0, 1, 0);
        add(0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0);
        // 1,1,0 then flush -> 0x03 / 3 bits / last
        add(0, 1, 1, 0, 1,  0, 0, 0, 0, 1, 0);
        add(0, 1, 1, 0, 1,  0, 0, 0, 0, 1, 0);
        add(0, 1, 0, 0, 1,  0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 1,  0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 1,  1, 'h03, 3, 1, 1, 0);
        // flush with empty word: nothing
        add(0, 0, 0, 1, 1,  0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0);
        // flush together with the 8th bit -> full word with last
        for (int i = 0; i < 8; i++) add(0, 1, int'(p3c[i]), (i == 7) ? 1 : 0, 1,  0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 1,  1, 'h3C, 8, 1, 1, 0);
        add(0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0);
        // reset mid-word: 5 bits, reset, then eight 1s -> only 0xFF
        for (int i = 0; i < 5; i++) add(0, 1, 1, 0, 1,  0, 0, 0, 0, 1, 0);
        add(1, 1, 1, 0, 1,  0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 8; i++) add(0, 1, 1, 0, 1,  0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 1,  1, 'hFF, 8, 0, 1, 0);
        add(0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0);

        repeat (2) @(posedge clk);
        foreach (vecs[i]) begin
            @(posedge clk); #1;
            rst = vecs[i].rst;
            a_in_valid = vecs[i].vld; a_in_bits[0] = vecs[i].din;
            a_flush = vecs[i].fl; a_out_ready = vecs[i].ordy;
            @(negedge clk);
            check($sformatf("vec%0d_out_valid", i), 32'(a_out_valid), 32'(vecs[i].ov));
            check($sformatf("vec%0d_in_ready", i),  32'(a_in_ready),  32'(vecs[i].irdy));
            if (vecs[i].ov || vecs[i].full) begin
                check($sformatf("vec%0d_out_data", i),  32'(a_out_data),  32'(vecs[i].dat));
                check($sformatf("vec%0d_out_nbits", i), 32'(a_out_nbits), 32'(vecs[i].nb));
                check($sformatf("vec%0d_out_last", i),  32'(a_out_last),  32'(vecs[i].last));
            end
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b1;

        // Streaming: 16 back-to-back bits, in_ready never drops, words 8 cycles apart.
        for (int i = 0; i < 16; i++) begin
            a_in_valid = 1'b1; a_in_bits[0] = pat[i];
            @(negedge clk);
            check($sformatf("stream_in_ready_%0d", i), 32'(a_in_ready), 1);
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        for (int k = 0; k < 30 && sb.size() != 0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("stream_drained", 32'(sb.size()), 0);
        check("stream_word_spacing", 32'(pop_cyc_last - pop_cyc_prev), 8);

        // Backpressure: consumer stalled while 16 bits are offered.
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a_in_valid = 1'b1; a_in_bits[0] = pat[i];
            got = 1'b0;
            for (int k = 0; k < 10 && !got; k++) begin
                @(negedge clk);
                got = a_in_ready;
            end
            if (!got) begin
                check($sformatf("bp_accept_timeout_%0d", i), 32'(a_in_ready), 1);
                break;
            end
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("bp_in_ready_low_%0d", k),  32'(a_in_ready),  0);
            check($sformatf("bp_out_valid_%0d", k),     32'(a_out_valid), 1);
            check($sformatf("bp_held_data_%0d", k),     32'(a_out_data),  'h8D);
        end
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        for (int k = 0; k < 30 && sb.size() != 0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("bp_drained", 32'(sb.size()), 0);
        check("bp_in_ready_back", 32'(a_in_ready), 1);

        // Instance B (N=4): 0xA, 0x5 -> 0x5A; then 0x7 + flush -> 0x07 / 4 bits / last.
        @(negedge clk);
        check("b_in_ready_idle", 32'(b_in_ready), 1);
        @(posedge clk); #1;
        b_in_valid = 1'b1; b_in_bits = 4'hA;
        @(posedge clk); #1;
        b_in_bits = 4'h5;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        @(negedge clk);
        check("b_full_valid", 32'(b_out_valid), 1);
        check("b_full_data",  32'(b_out_data),  'h5A);
        check("b_full_nbits", 32'(b_out_nbits), 8);
        check("b_full_last",  32'(b_out_last),  0);
        @(posedge clk); #1;
        b_in_valid = 1'b1; b_in_bits = 4'h7;
        @(posedge clk); #1;
        b_in_valid = 1'b0; b_flush = 1'b1;
        @(negedge clk);
        check("b_before_flush_valid", 32'(b_out_valid), 0);
        @(posedge clk); #1;
        b_flush = 1'b0;
        @(negedge clk);
        check("b_flush_valid", 32'(b_out_valid), 1);
        check("b_flush_data",  32'(b_out_data),  'h07);
        check("b_flush_nbits", 32'(b_out_nbits), 4);
        check("b_flush_last",  32'(b_out_last),  1);
        @(negedge clk);
        check("b_after_valid", 32'(b_out_valid), 0);

        check("sb_final_empty", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
